neg_seq_new: RTL

- Multi-cycle, parametrised two's-complement negate / absolute-value unit for the datapath.
- Invert-and-add-one runs CHUNK bits per cycle, with a registered carry between chunks. This keeps the adder narrow and timing short for wide operands.
- Adds a start/done handshake, an abs mode and an overflow flag, which the combinational 32-bit negate lacks.
- Sits beside the ALU; the control unit issues start and waits for done.

---
 rtl/neg_seq_new.sv | 122 ++++++++++++
 1 files changed

// File: rtl/neg_seq_new.sv
`default_nettype none
// ============================================================================
// Module   : neg_seq_new
// Brief    : Multi-cycle two's-complement negate / absolute value, CHUNK bits
//            per cycle with a registered inter-chunk carry.
//            Optional zero flag output z: define NEG_SEQ_ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neg_seq_new #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        x,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
`ifdef NEG_SEQ_ZERO_FLAG_EN
    ,
    output logic                    z
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op;
    logic             r_carry;
    logic [KW-1:0]    r_k;

    logic             w_accept;
    logic             w_last;
    logic             w_invert;
    logic             w_min;
    logic [CHUNK-1:0] w_op_chunk;
    logic [CHUNK:0]   w_sum;

    // Abs mode only inverts negative operands; negate always inverts.
    assign w_accept   = start && (r_state != S_RUN);
    assign w_last     = (r_k == KW'(NCH - 1));
    assign w_invert   = ~mode | x[WIDTH-1];
    assign w_min      = (x == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_op_chunk = r_op[r_k*CHUNK +: CHUNK];
    assign w_sum      = {1'b0, w_op_chunk} + {{CHUNK{1'b0}}, r_carry};

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            y       <= '0;
            ovf     <= 1'b0;
            r_op    <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_op    <= w_invert ? ~x : x;
            r_carry <= w_invert;
            ovf     <= w_min;
            r_k     <= '0;
        end else if (r_state == S_RUN) begin
            // Final carry-out of the top chunk is dropped on the next accept.
            y[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            r_carry               <= w_sum[CHUNK];
            r_k                   <= w_last ? '0 : r_k + 1'b1;
        end
    end

`ifdef NEG_SEQ_ZERO_FLAG_EN
    logic r_zacc;
    logic w_chunk_zero;

    assign w_chunk_zero = (w_sum[CHUNK-1:0] == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            z      <= 1'b0;
            r_zacc <= 1'b0;
        end else if (w_accept) begin
            z      <= 1'b0;
            r_zacc <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_zacc <= r_zacc & w_chunk_zero;
            if (w_last) begin
                z <= r_zacc & w_chunk_zero;
            end
        end
    end
`endif

endmodule
`default_nettype wire
